load_store_unit: RTL and testbench

Sequencer between the CPU's memory-access stage and an Avalon-style data-memory bus. It issues one load or store per request, inserts bus wait states, and aligns and extends load data. Load results drive the register file's load write port (write_enable_ld, write_data_ld, byteenable_ld), including the partial-register byte enables that LWL/LWR need.

---
 rtl/mips_lsu_pkg.sv | 45 ++++
 rtl/lsu_load_align.sv | 41 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: opcodes, FSM states
// and opcode classification helpers.
package mips_lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // LWL/LWR and byte accesses are legal at any byte offset.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] k);
        case (op)
            OP_LH, OP_LHU, OP_SH: return k[0];
            OP_LW, OP_SW:         return (k != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner: selects and extends the addressed lanes
// of a bus word and produces the register-file byte enables.
module lsu_load_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] i_readdata,
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_k,
    output logic [31:0] o_write_data_ld,
    output logic [3:0]  o_byteenable_ld
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_readdata[{i_k, 3'b000} +: 8];
    assign w_half = i_k[1] ? i_readdata[31:16] : i_readdata[15:0];

    // LWL/LWR merge into part of rt, so only some register lanes are written.
    always_comb begin
        o_write_data_ld = 32'h0;
        o_byteenable_ld = 4'b1111;
        case (i_opcode)
            OP_LB:  o_write_data_ld = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_write_data_ld = {24'h0, w_byte};
            OP_LH:  o_write_data_ld = {{16{w_half[15]}}, w_half};
            OP_LHU: o_write_data_ld = {16'h0, w_half};
            OP_LW:  o_write_data_ld = i_readdata;
            OP_LWL: begin
                o_write_data_ld = i_readdata << {2'd3 - i_k, 3'b000};
                o_byteenable_ld = 4'b1111 << (2'd3 - i_k);
            end
            OP_LWR: begin
                o_write_data_ld = i_readdata >> {i_k, 3'b000};
                o_byteenable_ld = 4'b1111 >> i_k;
            end
            default: o_byteenable_ld = 4'b0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequencer between the memory-access stage and an Avalon-style data bus:
// one load or store per request, wait-state aware, with load alignment.
module load_store_unit
    import mips_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        addr_error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        write_enable_ld,
    output logic [31:0] write_data_ld,
    output logic [3:0]  byteenable_ld
);

    state_t      r_state;
    state_t      w_nextState;

    logic [5:0]  r_opcode;
    logic [1:0]  r_k;
    logic        r_isLoad;
    logic        r_isStore;
    logic        r_addrErr;
    logic [31:0] r_memAddress;
    logic [3:0]  r_memByteenable;
    logic [31:0] r_memWritedata;
    logic [31:0] r_writeDataLd;
    logic [3:0]  r_byteenableLd;

    logic [31:0] w_ea;
    logic [1:0]  w_k;
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_busAccept;
    logic [3:0]  w_storeBe;
    logic [31:0] w_storeData;
    logic [31:0] w_alignData;
    logic [3:0]  w_alignBe;

    assign w_ea         = base + {{16{offset[15]}}, offset};
    assign w_k          = w_ea[1:0];
    assign w_isLoad     = is_load(opcode);
    assign w_isStore    = is_store(opcode);
    assign w_misaligned = is_misaligned(opcode, w_k);
    assign w_accept     = (r_state == IDLE) && start;
    assign w_busAccept  = (r_state == ACCESS) && !mem_waitrequest;

    // Store lanes: narrow data is replicated so the bus enables pick the lane.
    always_comb begin
        w_storeBe   = 4'b1111;
        w_storeData = store_data;
        case (opcode)
            OP_SB: begin
                w_storeBe   = 4'b0001 << w_k;
                w_storeData = {4{store_data[7:0]}};
            end
            OP_SH: begin
                w_storeBe   = w_k[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Misaligned and unsupported requests skip the bus entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((w_isLoad || w_isStore) && !w_misaligned) begin
                        w_nextState = ACCESS;
                    end else begin
                        w_nextState = FINISH;
                    end
                end
            end
            ACCESS: begin
                if (!mem_waitrequest) begin
                    w_nextState = FINISH;
                end
            end
            FINISH:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode        <= 6'h0;
            r_k             <= 2'b00;
            r_isLoad        <= 1'b0;
            r_isStore       <= 1'b0;
            r_addrErr       <= 1'b0;
            r_memAddress    <= 32'h0;
            r_memByteenable <= 4'b0000;
            r_memWritedata  <= 32'h0;
            r_writeDataLd   <= 32'h0;
            r_byteenableLd  <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_opcode        <= opcode;
                r_k             <= w_k;
                r_isLoad        <= w_isLoad && !w_misaligned;
                r_isStore       <= w_isStore && !w_misaligned;
                r_addrErr       <= (w_isLoad || w_isStore) && w_misaligned;
                r_memAddress    <= {w_ea[31:2], 2'b00};
                r_memByteenable <= w_isStore ? w_storeBe : 4'b1111;
                r_memWritedata  <= w_isStore ? w_storeData : 32'h0;
            end
            if (w_busAccept && r_isLoad) begin
                r_writeDataLd  <= w_alignData;
                r_byteenableLd <= w_alignBe;
            end
        end
    end

    lsu_load_align u_align (
        .i_readdata      (mem_readdata),
        .i_opcode        (r_opcode),
        .i_k             (r_k),
        .o_write_data_ld (w_alignData),
        .o_byteenable_ld (w_alignBe)
    );

    assign busy            = (r_state != IDLE);
    assign done            = (r_state == FINISH);
    assign addr_error      = (r_state == FINISH) && r_addrErr;
    assign mem_read        = (r_state == ACCESS) && r_isLoad;
    assign mem_write       = (r_state == ACCESS) && r_isStore;
    assign mem_address     = r_memAddress;
    assign mem_byteenable  = r_memByteenable;
    assign mem_writedata   = r_memWritedata;
    assign write_enable_ld = (r_state == FINISH) && r_isLoad;
    assign write_data_ld   = r_writeDataLd;
    assign byteenable_ld   = r_byteenableLd;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: stimulus pushes expected
// responses, a monitor pops and compares on bus strobes and done pulses.
module tb_load_store_unit;
    import mips_lsu_pkg::*;

    typedef struct {
        logic        isErr;
        logic        isLoad;
        logic        isStore;
        logic [31:0] addr;
        logic [3:0]  memBe;
        logic [31:0] wdata;
        logic [31:0] ldData;
        logic [3:0]  ldBe;
        int          doneCycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [15:0] offset;
    logic [31:0] store_data;
    logic        busy, done, addr_error;
    logic [31:0] mem_address;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        write_enable_ld;
    logic [31:0] write_data_ld;
    logic [3:0]  byteenable_ld;

    exp_t        expQ[$];
    int          cycleCnt = 0;
    int          waitLeft = 0;
    logic [31:0] curRdata = 32'h0;
    int          compared = 0;
    int          mismatched = 0;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .opcode          (opcode),
        .base            (base),
        .offset          (offset),
        .store_data      (store_data),
        .busy            (busy),
        .done            (done),
        .addr_error      (addr_error),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .write_enable_ld (write_enable_ld),
        .write_data_ld   (write_data_ld),
        .byteenable_ld   (byteenable_ld)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycleCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference model: works from the ISA rules with plain arithmetic.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] b, input logic [15:0] off,
                                   input logic [31:0] rt, input logic [31:0] rd, input int waits, input int startEdge);
        exp_t        e;
        logic [31:0] ea, bytev, halfv;
        int          kk;
        logic [3:0]  lwlTab [4];
        logic [3:0]  lwrTab [4];
        logic        supported, bad;
        lwlTab = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        lwrTab = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
        ea    = b + 32'($signed(off));
        kk    = int'(ea[1:0]);
        bytev = (rd >> (8 * kk)) & 32'hFF;
        halfv = (rd >> (16 * int'(ea[1]))) & 32'hFFFF;
        supported = (op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW});
        bad = ((op inside {OP_LH, OP_LHU, OP_SH}) && (ea % 2 != 0)) ||
              ((op inside {OP_LW, OP_SW}) && (ea % 4 != 0));
        e.isErr   = supported && bad;
        e.isLoad  = supported && !bad && (op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR});
        e.isStore = supported && !bad && (op inside {OP_SB, OP_SH, OP_SW});
        e.addr    = ea - (ea % 4);
        e.memBe   = 4'b1111;
        e.wdata   = rt;
        e.ldData  = rd;
        e.ldBe    = 4'b1111;
        case (op)
            OP_LB:  e.ldData = (bytev ^ 32'h80) - 32'h80;
            OP_LBU: e.ldData = bytev;
            OP_LH:  e.ldData = (halfv ^ 32'h8000) - 32'h8000;
            OP_LHU: e.ldData = halfv;
            OP_LWL: begin e.ldData = rd << (8 * (3 - kk)); e.ldBe = lwlTab[kk]; end
            OP_LWR: begin e.ldData = rd >> (8 * kk);       e.ldBe = lwrTab[kk]; end
            OP_SB:  begin e.memBe = 4'(1 << kk); e.wdata = rt[7:0] * 32'h01010101; end
            OP_SH:  begin e.memBe = (kk >= 2) ? 4'b1100 : 4'b0011; e.wdata = rt[15:0] * 32'h00010001; end
            default: ;
        endcase
        e.doneCycle = (e.isLoad || e.isStore) ? startEdge + 1 + waits : startEdge;
        return e;
    endfunction

    // Bus slave: stalls for the requested number of cycles, junk data while stalling.
    initial begin
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (waitLeft > 0) begin
                    mem_waitrequest = 1'b1;
                    mem_readdata    = $urandom;
                    waitLeft--;
                end else begin
                    mem_waitrequest = 1'b0;
                    mem_readdata    = curRdata;
                end
            end else begin
                mem_waitrequest = 1'($urandom_range(0, 1));
                mem_readdata    = $urandom;
            end
        end
    end

    // Monitor: compares bus activity and completions against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                checkOutput("rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
                if (mem_read || mem_write) begin
                    if (expQ.size() == 0) begin
                        checkOutput("stray_strobe", {30'h0, mem_read, mem_write}, 32'h0);
                    end else begin
                        e = expQ[0];
                        checkOutput("mem_read", {31'h0, mem_read}, {31'h0, e.isLoad});
                        checkOutput("mem_write", {31'h0, mem_write}, {31'h0, e.isStore});
                        checkOutput("mem_address", mem_address, e.addr);
                        checkOutput("mem_byteenable", {28'h0, mem_byteenable}, {28'h0, e.memBe});
                        if (e.isStore) checkOutput("mem_writedata", mem_writedata, e.wdata);
                    end
                end
                if (done) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_done", {31'h0, done}, 32'h0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("done_cycle", 32'(cycleCnt), 32'(e.doneCycle));
                        checkOutput("addr_error", {31'h0, addr_error}, {31'h0, e.isErr});
                        checkOutput("write_enable_ld", {31'h0, write_enable_ld}, {31'h0, e.isLoad});
                        if (e.isLoad) begin
                            checkOutput("write_data_ld", write_data_ld, e.ldData);
                            checkOutput("byteenable_ld", {28'h0, byteenable_ld}, {28'h0, e.ldBe});
                        end
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] b, input logic [15:0] off,
                                 input logic [31:0] rt, input logic [31:0] rd, input int waits);
        int budget;
        @(negedge clk);
        budget = 0;
        while ((busy || expQ.size() != 0) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            checkOutput("idle_timeout", {31'h0, busy}, 32'h0);
            expQ.delete();
        end
        opcode     = op;
        base       = b;
        offset     = off;
        store_data = rt;
        start      = 1'b1;
        curRdata   = rd;
        waitLeft   = waits;
        expQ.push_back(model(op, b, off, rt, rd, waits, cycleCnt + 1));
        @(negedge clk);
        start      = 1'b0;
        opcode     = 6'($urandom);
        base       = $urandom;
        offset     = 16'($urandom);
        store_data = $urandom;
        budget     = 0;
        // Starts raised while busy must be ignored; a wrong acceptance shows as an extra done.
        while (expQ.size() != 0 && budget < 60) begin
            start = busy && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        if (expQ.size() != 0) begin
            checkOutput("done_timeout", 32'(expQ.size()), 32'h0);
            expQ.delete();
        end
    endtask

    initial begin
        logic [5:0] ops [16];
        logic [3:0] pick;
        ops = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW,
                OP_SB, OP_LWL, 6'h00, 6'h0F, 6'h2A, 6'h3F};
        rst        = 1'b1;
        start      = 1'b0;
        opcode     = 6'h0;
        base       = 32'h0;
        offset     = 16'h0;
        store_data = 32'h0;
        #3;
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_addr_error", {31'h0, addr_error}, 32'h0);
        checkOutput("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        checkOutput("rst_we_ld", {31'h0, write_enable_ld}, 32'h0);
        checkOutput("rst_mem_address", mem_address, 32'h0);
        checkOutput("rst_mem_be", {28'h0, mem_byteenable}, 32'h0);
        checkOutput("rst_mem_wdata", mem_writedata, 32'h0);
        checkOutput("rst_ld_data", write_data_ld, 32'h0);
        checkOutput("rst_ld_be", {28'h0, byteenable_ld}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed requests");
        applyStimulus(OP_LW,  32'h100,  16'h0004, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus(OP_LB,  32'h100,  16'h0003, 32'h0, 32'h80112233, 2);
        applyStimulus(OP_LBU, 32'h100,  16'h0003, 32'h0, 32'h80112233, 2);
        applyStimulus(OP_LWL, 32'h200,  16'h0001, 32'h0, 32'hAABBCCDD, 0);
        applyStimulus(OP_LWR, 32'h200,  16'h0001, 32'h0, 32'hAABBCCDD, 1);
        applyStimulus(OP_SH,  32'h300,  16'h0002, 32'h12345678, 32'h0, 0);
        applyStimulus(OP_LW,  32'h100,  16'h0002, 32'h0, 32'h11111111, 0);
        applyStimulus(OP_LW,  32'h1000, 16'hFFFC, 32'h0, 32'hCAFEF00D, 0);
        applyStimulus(OP_LH,  32'h0,    16'h0002, 32'h0, 32'h8001_7FFF, 0);
        applyStimulus(6'h3F,  32'h40,   16'h0000, 32'h0, 32'h0, 0);

        $display("[TB] reset during a stalled access");
        @(negedge clk);
        opcode   = OP_LW;
        base     = 32'h400;
        offset   = 16'h0;
        start    = 1'b1;
        curRdata = $urandom;
        waitLeft = 50;
        expQ.push_back(model(OP_LW, 32'h400, 16'h0, 32'h0, curRdata, 50, cycleCnt + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_mem_read", {31'h0, mem_read}, 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_mem_read", {31'h0, mem_read}, 32'h0);
        checkOutput("async_rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("async_rst_address", mem_address, 32'h0);
        expQ.delete();
        waitLeft = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(OP_SW, 32'h500, 16'h0008, 32'hA5A55A5A, 32'h0, 1);

        $display("[TB] random requests");
        for (int i = 0; i < 200; i++) begin
            pick = 4'($urandom_range(0, 15));
            applyStimulus(ops[pick], $urandom, 16'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
